systolic_mac_pe: RTL
====================

Name: systolic_mac_pe

Overview:
- Compute stage directly downstream of the nibble-serial systolic transport node.
- Consumes the 16-bit column/row words and 4-bit control words that the transport node assembles at each block boundary (count==3).
- Performs a 2-lane signed int8 dot product, accumulates it into a saturating accumulator, and on command drains the accumulator as a 32-bit word plus a nibble-serial stream for pin output.

Parameters:
- ACC_W, 32, accumulator/result width; must be a multiple of 4, minimum 20.
- NIB_CNT, ACC_W/4, nibbles per drained result (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  one-cycle strobe; col/row words and ctrls are valid this cycle.
- col_word  in  16  {a1[15:8], a0[7:0]}, signed int8 lanes.
- row_word  in  16  {b1[15:8], b0[7:0]}, signed int8 lanes.
- col_ctrl  in  4  op bits: [0] operand valid, [1] clear, [2] drain, [3] reserved (ignored).
- row_ctrl  in  4  [0] operand valid; [3:1] ignored.
- busy  out  1  high while the MAC pipeline is not IDLE.
- acc_q  out  ACC_W  current accumulator value.
- result  out  ACC_W  last drained value; held until the next drain.
- out_valid  out  1  one-cycle pulse when result loads.
- res_nib  out  4  serial result nibble, MSB nibble first.
- res_active  out  1  high while res_nib carries a live nibble.
- sat  out  1  sticky saturation flag; cleared by a clear op.
- err  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset: every output and internal register is 0; FSM goes to IDLE. Reset asserted mid-operation aborts the pipeline and any serialization in progress; nothing from the aborted work is emitted.
- FSM states: IDLE -> MUL0 -> MUL1 -> ACC -> IDLE, one cycle each, with one shared 8x8 signed multiplier.
  - Edge T: IDLE and in_valid -> latch operands and ctrls; go to MUL0.
  - MUL0: p <= a1*b1 (16-bit signed).
  - MUL1: s <= p + a0*b0 (17-bit signed).
  - ACC: update the accumulator; go to IDLE.
- Accumulator update in ACC:
  - Accumulation is enabled only when col_ctrl[0] and row_ctrl[0] are both 1.
  - clear=1: base = 0 and sat <= 0; otherwise base = acc_q.
  - If enabled: acc_q <= sat_clamp(base + sext(s)). Otherwise acc_q <= base, so a bare clear zeroes the accumulator.
  - Overflow clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and sets sat. Clear plus overflow in the same op is impossible, since |s| <= 32768.
- Drain:
  - Drain in the same op: result <= new acc_q value, so the drained value includes this op's product and any clear. out_valid is high the cycle after ACC.
  - Serializer: starts at the out_valid cycle. res_nib = result[ACC_W-1:ACC_W-4] first, then the next lower nibble each cycle. res_active is high for exactly NIB_CNT cycles, and res_nib = 0 when inactive.
  - Drain while res_active is high: drain ignored (result and stream unchanged), err <= 1; the accumulate and clear parts of that op still execute.
- Latency: in_valid at edge T -> acc_q updated at edge T+3 -> out_valid high in cycle T+3..T+4. Block rate of 4 cycles per input is therefore sustainable.
- in_valid while busy: input dropped, err <= 1, in-flight op unaffected.
- Reserved ctrl bits never affect state.
- Arithmetic is two's complement throughout; no rounding.

Decomposition:
- Shared package systolic_pkg:
  - ACC_W default.
  - Ctrl bit index constants CTRL_VALID=0, CTRL_CLEAR=1, CTRL_DRAIN=2.
  - FSM state enum (IDLE, MUL0, MUL1, ACC).
  - Nibble width constant 4.
- Sub-module: result_nib_serializer (parallel-load, MSB-first nibble shifter with active flag and down-counter). It shares load/shift timing with the transport node's output path.

Test Plan:
- Basic MAC: clear+valid+drain, col=0x0302, row=0x0504 -> acc_q=23 at T+3; out_valid pulse; res_nib sequence 0,0,0,0,0,0,1,7.
- Signed extremes: clear+valid, col=0x80FF, row=0x80FF (-128*-128 + -1*-1) -> acc_q=16385; repeat without clear every 4 cycles -> 32770, 49155.
- Saturation with ACC_W=20: repeat col=0x7F7F, row=0x7F7F (32258 per op) without clear -> clamps at 524287, sat=1; a following clear+valid op -> acc_q=32258, sat=0.
- Protocol errors:
  - in_valid at T and T+1 -> second op dropped, err=1, acc_q reflects only the first op.
  - Two drains 4 cycles apart -> second drain ignored (stream continues uninterrupted), err=1, acc_q still accumulates.
- Invalid operand: col_ctrl valid=1, row_ctrl valid=0 -> acc_q unchanged; with the clear bit also set -> acc_q=0.
- Reset mid-op: assert rst_n=0 in MUL1 and during serialization -> next cycle all outputs 0, no out_valid emitted.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic compute slice: default accumulator
// width, control-word bit positions, nibble width and the MAC FSM states.
package systolic_pkg;
   localparam int ACC_W_DEF  = 32;
   localparam int NIB_W      = 4;
   localparam int CTRL_VALID = 0;
   localparam int CTRL_CLEAR = 1;
   localparam int CTRL_DRAIN = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL0 = 2'd1,
      MUL1 = 2'd2,
      ACC  = 2'd3
   } mac_state_e;
endpackage

// File: rtl/systolic_mac_pe_ser.sv
// result_nib_serializer: parallel-load, MSB-first nibble shifter.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : load data_i; its top nibble appears on nib_o next cycle
//   data_i     : ACC_W-bit word to stream out
//   nib_o      : current nibble (0 while inactive)
//   active_o   : high for exactly ACC_W/4 cycles after a load
module result_nib_serializer
   import systolic_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [ACC_W-1:0] data_i,
   output logic [NIB_W-1:0] nib_o,
   output logic             active_o
);
   localparam int NIB_CNT = ACC_W / NIB_W;
   localparam int CNT_W   = $clog2(NIB_CNT + 1);

   logic [ACC_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign active_o = (cnt_q != '0);
   assign nib_o    = active_o ? sh_q[ACC_W-1 -: NIB_W] : '0;

   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sh_d  = data_i;
         cnt_d = CNT_W'(NIB_CNT);
      end else if (active_o) begin
         sh_d  = {sh_q[ACC_W-NIB_W-1:0], {NIB_W{1'b0}}};
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: 2-lane signed int8 dot product into a saturating
// accumulator, with drain to a parallel result and a nibble stream.
//   in_valid, col_word, row_word, col_ctrl, row_ctrl : operand block strobe
//   busy       : MAC pipeline not idle
//   acc_q      : accumulator
//   result     : last drained value, out_valid pulses when it loads
//   res_nib    : MSB-first result nibbles, res_active marks live nibbles
//   sat        : sticky saturation (cleared by a clear op)
//   err        : sticky protocol error (cleared by reset only)
module systolic_mac_pe
   import systolic_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [15:0]      col_word,
   input  logic [15:0]      row_word,
   input  logic [3:0]       col_ctrl,
   input  logic [3:0]       row_ctrl,
   output logic             busy,
   output logic [ACC_W-1:0] acc_q,
   output logic [ACC_W-1:0] result,
   output logic             out_valid,
   output logic [3:0]       res_nib,
   output logic             res_active,
   output logic             sat,
   output logic             err
);
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   mac_state_e state_q, state_d;
   logic [15:0] col_q, col_d, row_q, row_d;
   logic        en_q, en_d, clr_q, clr_d, drn_q, drn_d;
   logic signed [15:0] p_q, p_d;
   logic signed [16:0] s_q, s_d;
   logic [ACC_W-1:0] acc_d, result_q, result_d, base;
   logic [ACC_W:0]   sum;
   logic             ovf, sat_q, sat_d, err_q, err_d, ov_q, ov_d, load;
   logic signed [7:0]  mul_a, mul_b;
   logic signed [15:0] prod;

   // Reserved control bits are deliberately dropped.
   logic unused_ctrl;
   assign unused_ctrl = ^{col_ctrl[3], row_ctrl[3:1]};

   // Single shared multiplier: high lanes in MUL0, low lanes in MUL1.
   assign mul_a = (state_q == MUL0) ? col_q[15:8] : col_q[7:0];
   assign mul_b = (state_q == MUL0) ? row_q[15:8] : row_q[7:0];
   assign prod  = mul_a * mul_b;

   // One extra bit catches overflow; s is sign-extended to ACC_W+1.
   assign base = clr_q ? '0 : acc_q;
   assign sum  = {base[ACC_W-1], base} + {{(ACC_W-16){s_q[16]}}, s_q};
   assign ovf  = sum[ACC_W] ^ sum[ACC_W-1];

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      en_d     = en_q;
      clr_d    = clr_q;
      drn_d    = drn_q;
      p_d      = p_q;
      s_d      = s_q;
      acc_d    = acc_q;
      result_d = result_q;
      sat_d    = sat_q;
      err_d    = err_q;
      ov_d     = 1'b0;
      load     = 1'b0;
      if (in_valid && state_q != IDLE) err_d = 1'b1;
      unique case (state_q)
         IDLE: if (in_valid) begin
            col_d   = col_word;
            row_d   = row_word;
            en_d    = col_ctrl[CTRL_VALID] & row_ctrl[CTRL_VALID];
            clr_d   = col_ctrl[CTRL_CLEAR];
            drn_d   = col_ctrl[CTRL_DRAIN];
            state_d = MUL0;
         end
         MUL0: begin
            p_d     = prod;
            state_d = MUL1;
         end
         MUL1: begin
            s_d     = {p_q[15], p_q} + {prod[15], prod};
            state_d = ACC;
         end
         ACC: begin
            if (en_q) acc_d = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
            else      acc_d = base;
            sat_d = (sat_q & ~clr_q) | (en_q & ovf);
            // A drain that would cut a live stream short is rejected.
            if (drn_q && res_active) err_d = 1'b1;
            if (drn_q && !res_active) begin
               load     = 1'b1;
               ov_d     = 1'b1;
               result_d = acc_d;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         en_q     <= 1'b0;
         clr_q    <= 1'b0;
         drn_q    <= 1'b0;
         p_q      <= '0;
         s_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         sat_q    <= 1'b0;
         err_q    <= 1'b0;
         ov_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         en_q     <= en_d;
         clr_q    <= clr_d;
         drn_q    <= drn_d;
         p_q      <= p_d;
         s_q      <= s_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         sat_q    <= sat_d;
         err_q    <= err_d;
         ov_q     <= ov_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign out_valid = ov_q;
   assign sat       = sat_q;
   assign err       = err_q;

   result_nib_serializer #(.ACC_W(ACC_W)) u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load),
      .data_i   (acc_d),
      .nib_o    (res_nib),
      .active_o (res_active)
   );
endmodule
